// File: rtl/upc_loop_monitor.sv
// Performance monitor for an HLS-style module and one of its pipelined loops:
// counts module transactions, busy cycles, loop runs, iterations and stall cycles.
module upc_loop_monitor #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic [CNT_W-1:0]   mod_txn_cnt,
  output logic [CNT_W-1:0]   mod_busy_cyc,
  output logic [CNT_W-1:0]   loop_run_cnt,
  output logic [CNT_W-1:0]   iter_cnt,
  output logic [CNT_W-1:0]   stall_cyc,
  output logic               loop_active,
  output logic               frozen
);

  typedef enum logic {
    MOD_IDLE,
    MOD_BUSY
  } mod_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mod_state_t mod_state;
  mod_state_t mod_next;
  logic       mod_done;
  logic       s_iter_start;
  logic       s_iter_end;
  logic       s_quit;
  logic       f_iter_end;
  logic       f_quit;
  logic       stall_hit;
  logic       loop_exit;
  logic       loop_next;
  logic       unused_inputs;

  // Handshake-only inputs: accepted for interface completeness, not monitored.
  assign unused_inputs = ap_ready ^ loop_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign s_iter_start = (cur_state == iter_start_state) & iter_start_enable;
  assign s_iter_end   = (cur_state == iter_end_state) & iter_end_enable;
  assign s_quit       = (cur_state == quit_state) & quit_enable;
  assign f_iter_end   = s_iter_end & ~iter_end_block;
  assign f_quit       = s_quit & ~quit_block;

  assign stall_hit = loop_active &
                     ((s_iter_start & iter_start_block) | (s_iter_end & iter_end_block));
  assign loop_exit = loop_active & ((quit_at_end & f_quit) | (loop_done & loop_continue));
  // An exit coinciding with loop_start re-arms immediately.
  assign loop_next = loop_exit ? loop_start : (loop_active | loop_start);

  always_comb begin
    mod_next = mod_state;
    mod_done = 1'b0;
    case (mod_state)
      MOD_IDLE: if (ap_start) mod_next = MOD_BUSY;
      MOD_BUSY: begin
        if (ap_done && ap_continue) begin
          mod_done = 1'b1;
          mod_next = ap_start ? MOD_BUSY : MOD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mod_state <= MOD_IDLE;
    end else if (!frozen) begin
      mod_state <= mod_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mod_txn_cnt  <= '0;
      mod_busy_cyc <= '0;
      loop_run_cnt <= '0;
      iter_cnt     <= '0;
      stall_cyc    <= '0;
      loop_active  <= 1'b0;
      frozen       <= 1'b0;
    end else if (!frozen) begin
      loop_active <= loop_next;
      if (mod_state == MOD_BUSY) mod_busy_cyc <= sat_inc(mod_busy_cyc);
      if (mod_done)              mod_txn_cnt  <= sat_inc(mod_txn_cnt);
      if (loop_exit)             loop_run_cnt <= sat_inc(loop_run_cnt);
      if (loop_active && f_iter_end) iter_cnt <= sat_inc(iter_cnt);
      if (stall_hit)             stall_cyc    <= sat_inc(stall_cyc);
      if (finish)                frozen       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Scoreboard bench for upc_loop_monitor: two instances (16-bit and 4-bit counters)
// driven in parallel, checked against an unbounded-count reference with clamping.
module tb_upc_loop_monitor;

  logic       clock;
  logic       reset;
  logic       finish;
  logic       ap_start, ap_ready, ap_done, ap_continue;
  logic [1:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic       iter_start_block, iter_end_block, quit_block;
  logic       iter_start_enable, iter_end_enable, quit_enable;
  logic       loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

  logic [15:0] w_txn, w_busy, w_run, w_iter, w_stall;
  logic        w_active, w_frozen;
  logic [3:0]  n_txn, n_busy, n_run, n_iter, n_stall;
  logic        n_active, n_frozen;

  upc_loop_monitor #(.STATE_W(2), .CNT_W(16)) dut_w (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
    .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_txn_cnt(w_txn), .mod_busy_cyc(w_busy), .loop_run_cnt(w_run), .iter_cnt(w_iter),
    .stall_cyc(w_stall), .loop_active(w_active), .frozen(w_frozen)
  );

  upc_loop_monitor #(.STATE_W(2), .CNT_W(4)) dut_n (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
    .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_txn_cnt(n_txn), .mod_busy_cyc(n_busy), .loop_run_cnt(n_run), .iter_cnt(n_iter),
    .stall_cyc(n_stall), .loop_active(n_active), .frozen(n_frozen)
  );

  typedef struct {
    bit       rst_n, fin, st, rdy, dn, cont;
    bit [1:0] cur, iss, ies, qs;
    bit       isb, ieb, qb, ise, iee, qe;
    bit       ls, lr, ld, lc, qae;
  } stim_t;

  typedef struct {
    int txn, busy, run, iter, stall;
    bit active, frozen;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: plain event counts; each instance's expectation is the count clamped.
  int m_txn, m_busy_cyc, m_run, m_iter, m_stall;
  bit m_busy, m_active, m_frozen;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic void model_reset();
    m_txn = 0; m_busy_cyc = 0; m_run = 0; m_iter = 0; m_stall = 0;
    m_busy = 0; m_active = 0; m_frozen = 0;
  endfunction

  function automatic void model_step(input stim_t s);
    bit s_is, s_ie, s_q;
    if (!s.rst_n) begin
      model_reset();
      return;
    end
    if (m_frozen) return;
    s_is = (s.cur == s.iss) && s.ise;
    s_ie = (s.cur == s.ies) && s.iee;
    s_q  = (s.cur == s.qs) && s.qe;
    if (m_busy) begin
      m_busy_cyc++;
      if (s.dn && s.cont) begin
        m_txn++;
        m_busy = s.st;
      end
    end else begin
      m_busy = s.st;
    end
    if (m_active) begin
      if (s_ie && !s.ieb) m_iter++;
      if ((s_is && s.isb) || (s_ie && s.ieb)) m_stall++;
      if ((s.qae && s_q && !s.qb) || (s.ld && s.lc)) begin
        m_run++;
        m_active = s.ls;
      end
    end else begin
      m_active = s.ls;
    end
    if (s.fin) m_frozen = 1;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.txn = m_txn; e.busy = m_busy_cyc; e.run = m_run; e.iter = m_iter; e.stall = m_stall;
    e.active = m_active; e.frozen = m_frozen;
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s = '{default: 0};
    s.rst_n = 1; s.iss = 2'd1; s.ies = 2'd2; s.qs = 2'd3;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n = ($urandom_range(0, 99) != 0);
    s.fin   = ($urandom_range(0, 249) == 0);
    s.st    = ($urandom_range(0, 3) == 0);
    s.rdy   = $urandom_range(0, 1);
    s.dn    = ($urandom_range(0, 2) == 0);
    s.cont  = $urandom_range(0, 1);
    s.cur   = 2'($urandom_range(0, 3));
    s.iss   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
    s.ies   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
    s.qs    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
    s.isb   = ($urandom_range(0, 2) == 0);
    s.ieb   = ($urandom_range(0, 2) == 0);
    s.qb    = ($urandom_range(0, 2) == 0);
    s.ise   = $urandom_range(0, 1);
    s.iee   = $urandom_range(0, 1);
    s.qe    = $urandom_range(0, 1);
    s.ls    = ($urandom_range(0, 7) == 0);
    s.lr    = $urandom_range(0, 1);
    s.ld    = ($urandom_range(0, 5) == 0);
    s.lc    = $urandom_range(0, 1);
    s.qae   = $urandom_range(0, 1);
    return s;
  endfunction

  // Called at a falling edge: applies inputs, advances the reference, queues the
  // outputs expected after the next rising edge, then waits for the next falling edge.
  task automatic drive(input stim_t s);
    reset = s.rst_n; finish = s.fin;
    ap_start = s.st; ap_ready = s.rdy; ap_done = s.dn; ap_continue = s.cont;
    cur_state = s.cur; iter_start_state = s.iss; iter_end_state = s.ies; quit_state = s.qs;
    iter_start_block = s.isb; iter_end_block = s.ieb; quit_block = s.qb;
    iter_start_enable = s.ise; iter_end_enable = s.iee; quit_enable = s.qe;
    loop_start = s.ls; loop_ready = s.lr; loop_done = s.ld; loop_continue = s.lc;
    quit_at_end = s.qae;
    model_step(s);
    exp_q.push_back(snap());
    @(negedge clock);
  endtask

  task automatic do_reset();
    stim_t s = idle();
    s.rst_n = 0;
    drive(s);
    drive(s);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".w_txn"}, w_txn, 0);     chk({tag, ".w_busy"}, w_busy, 0);
    chk({tag, ".w_run"}, w_run, 0);     chk({tag, ".w_iter"}, w_iter, 0);
    chk({tag, ".w_stall"}, w_stall, 0); chk({tag, ".w_active"}, w_active, 0);
    chk({tag, ".w_frozen"}, w_frozen, 0);
    chk({tag, ".n_txn"}, n_txn, 0);     chk({tag, ".n_busy"}, n_busy, 0);
    chk({tag, ".n_iter"}, n_iter, 0);   chk({tag, ".n_frozen"}, n_frozen, 0);
  endtask

  // Monitor: outputs are registered, so they are sampled just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("w.mod_txn_cnt",  w_txn,    clamp(e.txn, 65535));
        chk("w.mod_busy_cyc", w_busy,   clamp(e.busy, 65535));
        chk("w.loop_run_cnt", w_run,    clamp(e.run, 65535));
        chk("w.iter_cnt",     w_iter,   clamp(e.iter, 65535));
        chk("w.stall_cyc",    w_stall,  clamp(e.stall, 65535));
        chk("w.loop_active",  w_active, e.active);
        chk("w.frozen",       w_frozen, e.frozen);
        chk("n.mod_txn_cnt",  n_txn,    clamp(e.txn, 15));
        chk("n.mod_busy_cyc", n_busy,   clamp(e.busy, 15));
        chk("n.loop_run_cnt", n_run,    clamp(e.run, 15));
        chk("n.iter_cnt",     n_iter,   clamp(e.iter, 15));
        chk("n.stall_cyc",    n_stall,  clamp(e.stall, 15));
        chk("n.loop_active",  n_active, e.active);
        chk("n.frozen",       n_frozen, e.frozen);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    s = idle();
    reset = 1'b1; finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = 0; iter_start_state = 1; iter_end_state = 2; quit_state = 3;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
    #1 reset = 1'b0;
    #1 check_all_zero("reset_state");
    @(negedge clock);

    // Single transaction: start, five quiet cycles, then done with acknowledge.
    do_reset();
    s = idle(); s.st = 1; drive(s);
    repeat (5) drive(idle());
    s = idle(); s.dn = 1; s.cont = 1; drive(s);
    chk("txn1.mod_txn_cnt", w_txn, 1);
    chk("txn1.mod_busy_cyc", w_busy, 6);

    // Done held off by continue, then back-to-back transactions.
    do_reset();
    s = idle(); s.st = 1; drive(s);
    s = idle(); s.dn = 1; repeat (3) drive(s);
    s.cont = 1; drive(s);
    chk("hold.mod_txn_cnt", w_txn, 1);
    chk("hold.mod_busy_cyc", w_busy, 4);
    s = idle(); s.st = 1; drive(s);
    s = idle(); s.st = 1; s.dn = 1; s.cont = 1; drive(s);
    s = idle(); s.dn = 1; s.cont = 1; drive(s);
    chk("b2b.mod_txn_cnt", w_txn, 3);
    chk("b2b.mod_busy_cyc", w_busy, 6);

    // Loop: four iterations, two blocked cycles, quit.
    do_reset();
    s = idle(); s.ls = 1; drive(s);
    s = idle(); s.cur = 2; s.iee = 1; repeat (4) drive(s);
    s = idle(); s.cur = 1; s.ise = 1; s.isb = 1; repeat (2) drive(s);
    s = idle(); s.cur = 3; s.qe = 1; s.qae = 1; drive(s);
    chk("loop.iter_cnt", w_iter, 4);
    chk("loop.stall_cyc", w_stall, 2);
    chk("loop.loop_run_cnt", w_run, 1);
    chk("loop.loop_active", w_active, 0);

    // Quit ignored without quit_at_end; done-exit; exit coinciding with restart.
    do_reset();
    s = idle(); s.ls = 1; drive(s);
    s = idle(); s.cur = 3; s.qe = 1; drive(s);
    chk("noquit.loop_active", w_active, 1);
    chk("noquit.loop_run_cnt", w_run, 0);
    s = idle(); s.ld = 1; s.lc = 1; drive(s);
    chk("doneexit.loop_active", w_active, 0);
    chk("doneexit.loop_run_cnt", w_run, 1);
    s = idle(); s.ls = 1; drive(s);
    s = idle(); s.ld = 1; s.lc = 1; s.ls = 1; drive(s);
    chk("restart.loop_active", w_active, 1);
    chk("restart.loop_run_cnt", w_run, 2);

    // Saturation of the narrow instance.
    do_reset();
    s = idle(); s.ls = 1; drive(s);
    s = idle(); s.cur = 2; s.iee = 1; repeat (20) drive(s);
    chk("sat.n_iter_cnt", n_iter, 15);
    chk("sat.w_iter_cnt", w_iter, 20);

    // Freeze: the finish cycle still counts, later events do not.
    do_reset();
    s = idle(); s.ls = 1; drive(s);
    s = idle(); s.cur = 2; s.iee = 1; repeat (2) drive(s);
    s.fin = 1; drive(s);
    s.fin = 0; s.st = 1; repeat (5) drive(s);
    chk("freeze.frozen", w_frozen, 1);
    chk("freeze.iter_cnt", w_iter, 3);
    chk("freeze.mod_busy_cyc", w_busy, 0);

    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    do_reset();

    // Randomised traffic.
    repeat (700) drive(rand_stim());

    // Activity, then an asynchronous reset mid-cycle.
    s = idle(); s.ls = 1; s.st = 1; drive(s);
    s = idle(); s.cur = 2; s.iee = 1; repeat (3) drive(s);
    #3 reset = 1'b0;
    #1 check_all_zero("async_reset2");
    model_reset();
    do_reset();
    repeat (100) drive(rand_stim());
    drive(idle());
    drive(idle());

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
